// File: rtl/s_term_dsp_trace_capture.sv
// ---------------------------------------------------------------------------
// s_term_dsp_trace_capture
//
// Trigger-based trace capture on the southbound S-wire bundle below the DSP
// column. The bundle is registered every cycle. Once armed, the block waits for
// a masked trigger match. It then stores the trigger sample and post_count
// further samples in a first-word-fall-through FIFO. The FIFO drains over a
// valid/ready port.
//
// Optional feature macro: S_TERM_TRACE_TIMESTAMP_EN
//   When defined, a free-running 16-bit cycle counter is stored with each
//   entry and presented on tr_ts alongside tr_data.
//
// Ports
//   UserCLK, reset          clock, asynchronous active-high reset
//   S1END..SS4END           southbound wires, bundle {SS4END,S4END,S2END,S2MID,S1END}
//   arm                     pulse: start capture (accepted in IDLE / DONE)
//   trig_mask, trig_value   masked trigger compare against the sampled bundle
//   post_count              samples stored after the trigger sample
//   tr_data/tr_valid/tr_ready  FIFO head, valid/ready stream
//   busy, done, overflow    status (overflow sticky until next arm)
//   tr_ts                   entry timestamp (only with S_TERM_TRACE_TIMESTAMP_EN)
// ---------------------------------------------------------------------------
module s_term_dsp_trace_capture #(
    parameter int WIDTH  = 52,
    parameter int DEPTH  = 16,
    parameter int POST_W = 8
) (
    input  logic              UserCLK,
    input  logic              reset,
    input  logic [3:0]        S1END,
    input  logic [7:0]        S2MID,
    input  logic [7:0]        S2END,
    input  logic [15:0]       S4END,
    input  logic [15:0]       SS4END,
    input  logic              arm,
    input  logic [WIDTH-1:0]  trig_mask,
    input  logic [WIDTH-1:0]  trig_value,
    input  logic [POST_W-1:0] post_count,
    output logic [WIDTH-1:0]  tr_data,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef S_TERM_TRACE_TIMESTAMP_EN
    ,
    output logic [15:0]       tr_ts
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  samp_q, samp_d;
    logic [POST_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              hit, push, pop, full, wr_en;

`ifdef S_TERM_TRACE_TIMESTAMP_EN
    logic [15:0]       ts_q, ts_d;
    logic [15:0]       ts_mem_q [DEPTH];
`endif

    always_comb begin
        samp_d     = {SS4END, S4END, S2END, S2MID, S1END};
        hit        = ((samp_q ^ trig_value) & trig_mask) == '0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        push       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d    = ARMED;
                    overflow_d = 1'b0;
                end
            end
            ARMED: begin
                if (hit) begin
                    push = 1'b1;
                    if (post_count == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = post_count;
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                push  = 1'b1;
                cnt_d = cnt_q - POST_W'(1);
                if (cnt_q == POST_W'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        full  = (count_q == FULL_CNT);
        pop   = (count_q != '0) && tr_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_en = push && (!full || pop);
        if (push && full && !pop) overflow_d = 1'b1;

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);

        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
`ifdef S_TERM_TRACE_TIMESTAMP_EN
        ts_d = ts_q + 16'd1;
`endif
    end

    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            samp_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef S_TERM_TRACE_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            samp_q     <= samp_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef S_TERM_TRACE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge UserCLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= samp_q;
`ifdef S_TERM_TRACE_TIMESTAMP_EN
            ts_mem_q[wr_ptr_q] <= ts_q;
`endif
        end
    end

    assign tr_valid = (count_q != '0);
    assign tr_data  = tr_valid ? mem_q[rd_ptr_q] : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
`ifdef S_TERM_TRACE_TIMESTAMP_EN
    assign tr_ts    = tr_valid ? ts_mem_q[rd_ptr_q] : '0;
`endif

endmodule
